med_ctrl: RTL and testbench

- Sequencer for the 9-tap median datapath MED, which contains a register ring plus one compare-exchange unit and has no enable.
- Accepts a burst of NBR pixels through a valid/ready handshake and drives MED's DSI/BYP lines through the load phase and the sort passes.
- Pulses OUT_VALID on the single cycle when MED's DO holds the median.
- Pixel data goes straight from upstream to MED DI; this block handles only control.
- Instantiated beside MED inside the median top level.

---
 rtl/med_pkg.sv | 17 +
 rtl/med_ctrl.sv | 132 +++++++++++++
 tb/tb_med_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/med_pkg.sv
// Shared types and sizing for the 9-tap median sequencer.
// NBR must match the register-ring length of the MED datapath.
package med_pkg;

  localparam int NBR         = 9;
  localparam int NPASS       = (NBR - 1) / 2;
  localparam int CNT_W       = $clog2(NBR);
  localparam int SORT_CYCLES = NPASS * NBR + (NBR - 1 - NPASS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DONE
  } med_state_t;

endpackage

// File: rtl/med_ctrl.sv
// Control sequencer for the MED median ring: loads an NBR-pixel burst, runs the
// max-elimination passes, then flags the single cycle where DO holds the median.
module med_ctrl
  import med_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic IN_VALID,
  output logic IN_READY,
  output logic MED_DSI,
  output logic MED_BYP,
  output logic OUT_VALID,
  output logic ERR
);

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NBR - 1);
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(NBR - 1);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NPASS);
  localparam logic [CNT_W-1:0] FINAL_END = CNT_W'(NBR - 2 - NPASS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  med_state_t       state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, pix_nxt;
  logic [CNT_W-1:0] pass_cnt, pass_nxt;
  logic [CNT_W-1:0] cyc_cnt, cyc_nxt;
  logic             err_q, err_nxt;
  logic             accept;
  logic             byp_sort;

  assign IN_READY  = ~RST & (state != SORT);
  assign accept    = IN_VALID & IN_READY;
  assign MED_DSI   = accept;
  assign MED_BYP   = RST | byp_sort;
  assign OUT_VALID = ~RST & (state == DONE);
  assign ERR       = ~RST & err_q;

  always_comb begin
    state_nxt = state;
    pix_nxt   = pix_cnt;
    pass_nxt  = pass_cnt;
    cyc_nxt   = cyc_cnt;
    err_nxt   = 1'b0;
    byp_sort  = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
          pix_nxt   = ONE;
        end
      end

      LOAD: begin
        if (accept) begin
          if (pix_cnt == LAST_PIX) begin
            state_nxt = SORT;
            pix_nxt   = '0;
            pass_nxt  = '0;
            cyc_nxt   = '0;
          end else begin
            pix_nxt = pix_cnt + ONE;
          end
        end else begin
          // The ring shifts every cycle, so a gap leaves it holding a stale pixel.
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          pix_nxt   = '0;
          pass_nxt  = '0;
          cyc_nxt   = '0;
        end
      end

      SORT: begin
        if (pass_cnt == LAST_PASS) begin
          byp_sort = 1'b0;
          if (cyc_cnt == FINAL_END) begin
            state_nxt = DONE;
            pass_nxt  = '0;
            cyc_nxt   = '0;
          end else begin
            cyc_nxt = cyc_cnt + ONE;
          end
        end else begin
          // Pass p retires p maxima already parked at the tail; those just rotate.
          byp_sort = (cyc_cnt >= (LAST_CYC - pass_cnt));
          if (cyc_cnt == LAST_CYC) begin
            cyc_nxt  = '0;
            pass_nxt = pass_cnt + ONE;
          end else begin
            cyc_nxt = cyc_cnt + ONE;
          end
        end
      end

      DONE: begin
        pass_nxt = '0;
        cyc_nxt  = '0;
        if (accept) begin
          state_nxt = LOAD;
          pix_nxt   = ONE;
        end else begin
          state_nxt = IDLE;
          pix_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        pix_nxt   = '0;
        pass_nxt  = '0;
        cyc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      pass_cnt <= '0;
      cyc_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pix_cnt  <= pix_nxt;
      pass_cnt <= pass_nxt;
      cyc_cnt  <= cyc_nxt;
      err_q    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_med_ctrl.sv
// Scoreboard bench for med_ctrl: a window-timeline model predicts handshake,
// BYP schedule and the OUT_VALID/ERR events, which a monitor checks each cycle.
module tb_med_ctrl;

  localparam int NBR      = 9;
  localparam int NPASS    = (NBR - 1) / 2;
  localparam int DONE_REL = NBR + NPASS * NBR + (NBR - 1 - NPASS);

  typedef struct {
    int cyc;
    bit is_err;
  } ev_t;

  logic CLK = 1'b0;
  logic RST;
  logic IN_VALID;
  logic IN_READY, MED_DSI, MED_BYP, OUT_VALID, ERR;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  rel   = -1;
  bit  sched[$];
  ev_t q[$];

  med_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .MED_DSI  (MED_DSI),
    .MED_BYP  (MED_BYP),
    .OUT_VALID(OUT_VALID),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // BYP pattern during SORT, straight from the pass description.
  initial begin
    for (int p = 0; p < NPASS; p++)
      for (int c = 0; c < NBR; c++)
        sched.push_back(c >= NBR - 1 - p);
    for (int c = 0; c < NBR - 1 - NPASS; c++)
      sched.push_back(1'b0);
  end

  // Model: rel = cycles since the current window's first accept, -1 when idle.
  always @(posedge CLK) begin
    if (RST) begin
      rel <= -1;
      q.delete();
    end else if (rel < 0 || rel == DONE_REL) begin
      rel <= IN_VALID ? 1 : -1;
    end else if (rel < NBR) begin
      if (IN_VALID) begin
        rel <= rel + 1;
      end else begin
        rel <= -1;
        q.push_back(ev_t'{cyc + 1, 1'b1});
      end
    end else begin
      rel <= rel + 1;
      if (rel + 1 == DONE_REL) q.push_back(ev_t'{cyc + 1, 1'b0});
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d rel=%0d got=%0b want=%0b", name, cyc, rel, act, exp);
    end
  endtask

  // Monitor
  always @(negedge CLK) begin
    bit   in_sort;
    logic exp_ready, exp_byp;
    ev_t  e;
    in_sort   = (rel >= NBR) && (rel < DONE_REL);
    exp_ready = !RST && !in_sort;
    exp_byp   = RST || !in_sort || sched[rel - NBR];
    chk("in_ready", IN_READY, exp_ready);
    chk("med_dsi", MED_DSI, exp_ready && IN_VALID);
    chk("med_byp", MED_BYP, exp_byp);
    if (OUT_VALID || ERR) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cycle=%0d got out_valid=%0b err=%0b want none",
                 cyc, OUT_VALID, ERR);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || OUT_VALID == ERR || ERR != e.is_err) begin
          bad++;
          $display("FAIL event cycle=%0d got out_valid=%0b err=%0b want err=%0b at cycle %0d",
                   cyc, OUT_VALID, ERR, e.is_err, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      total++;
      bad++;
      e = q.pop_front();
      $display("FAIL missed_event cycle=%0d got none want err=%0b at cycle %0d",
               cyc, e.is_err, e.cyc);
    end
  end

  task automatic run(input bit v, input bit r, input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      IN_VALID = v;
      RST      = r;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b1;
    run(1, 1, 2);
    run(0, 0, 3);
    // nominal window
    run(1, 0, 9);
    run(0, 0, 55);
    // broken burst, then a clean one
    run(1, 0, 5);
    run(0, 0, 3);
    run(1, 0, 9);
    run(0, 0, 55);
    // back-to-back windows
    run(1, 0, 100);
    run(0, 0, 60);
    // reset in the middle of SORT
    run(1, 0, 9);
    run(0, 0, 11);
    run(0, 1, 1);
    run(0, 0, 5);
    // random traffic with rare resets
    for (int i = 0; i < 2000; i++)
      run($urandom_range(0, 15) != 0, $urandom_range(0, 299) == 0, 1);
    run(0, 0, 60);
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
